// File: rtl/packet_checker.sv
// packet_checker: AXI4-Stream sink that checks a generator's packet stream.
// It receives a stream and checks each beat against the expected pattern:
//   - a 16-bit rolling counter repeated across tdata,
//   - a fixed packet length,
//   - the expected tkeep and tlast placement.
// tready can be throttled so that the upstream sees backpressure.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   packet_length       expected bytes per packet (sampled on start)
//   packet_count        packets to receive before returning idle (sampled on start)
//   initial_value       expected counter value of the first beat (sampled on start)
//   stall_cycles        tready-low cycles after each accepted beat (sampled on start)
//   start               single-cycle arm pulse
//   active              high while armed
//   axis_in_*           AXI4-Stream input (tdata/tkeep/tlast/tvalid/tready)
//   packets_rcvd        tlast beats accepted since start (wraps)
//   error_count         beats with at least one error (saturates)
//   error_flags         sticky flags:
//                         [0] data, [1] tkeep, [2] tlast early, [3] tlast missing
//   first_err_packet    1-based packet number of the first erroneous beat
//   first_err_cycle     1-based beat number of the first erroneous beat
module packet_checker #(
    parameter int DW = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       packet_length,
    input  logic [15:0]       packet_count,
    input  logic [15:0]       initial_value,
    input  logic [7:0]        stall_cycles,
    input  logic              start,
    output logic              active,
    input  logic [DW-1:0]     axis_in_tdata,
    input  logic [DW/8-1:0]   axis_in_tkeep,
    input  logic              axis_in_tlast,
    input  logic              axis_in_tvalid,
    output logic              axis_in_tready,
    output logic [15:0]       packets_rcvd,
    output logic [15:0]       error_count,
    output logic [3:0]        error_flags,
    output logic [15:0]       first_err_packet,
    output logic [15:0]       first_err_cycle
);
    localparam int DB     = DW / 8;
    localparam int LOG2DB = $clog2(DB);
    localparam int NW     = DW / 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t              state_r;
    logic [15:0]         nbeats_r;
    logic [LOG2DB-1:0]   partial_r;
    logic [15:0]         count_r;
    logic [7:0]          stall_r;
    logic [7:0]          stall_ctr_r;
    logic [15:0]         exp_data_r;
    logic [15:0]         beat_r;
    logic [15:0]         pkt_r;
    logic                tready_r;
    logic                active_r;
    logic [15:0]         packets_rcvd_r;
    logic [15:0]         error_count_r;
    logic [3:0]          error_flags_r;
    logic [15:0]         first_err_packet_r;
    logic [15:0]         first_err_cycle_r;

    // Byte mask with the low n bytes enabled (last beat of a partial packet).
    function automatic logic [DB-1:0] partial_keep(input logic [LOG2DB-1:0] n);
        logic [DB-1:0] m;
        m = '0;
        for (int i = 0; i < DB; i++) begin
            m[i] = (i < int'(n));
        end
        return m;
    endfunction

    // True when any enabled byte of d differs from the same byte of p.
    function automatic logic data_mismatch(input logic [DW-1:0] d,
                                           input logic [DW-1:0] p,
                                           input logic [DB-1:0] k);
        logic m;
        m = 1'b0;
        for (int i = 0; i < DB; i++) begin
            m = m | (k[i] & (d[i*8 +: 8] != p[i*8 +: 8]));
        end
        return m;
    endfunction

    logic [LOG2DB-1:0]   arm_partial_s;
    logic [15:0]         arm_nbeats_s;
    logic                arm_ok_s;
    logic                hs_s;
    logic                chk_s;
    logic [DB-1:0]       exp_keep_s;
    logic [DW-1:0]       exp_pattern_s;
    logic [3:0]          err_s;

    // Arm-time derived values, handshake, and per-beat error evaluation.
    always_comb begin
        arm_partial_s = packet_length[LOG2DB-1:0];
        arm_nbeats_s  = (packet_length >> LOG2DB)
                      + {15'd0, (arm_partial_s != {LOG2DB{1'b0}})};
        arm_ok_s      = start && (packet_length != 16'd0) && (packet_count != 16'd0);
        hs_s          = axis_in_tvalid && tready_r && (state_r == ST_RECV);
        // Beats past N (tlast missing already reported) are not checked.
        chk_s         = (beat_r <= nbeats_r);
        exp_pattern_s = {NW{exp_data_r}};
        if ((beat_r == nbeats_r) && (partial_r != {LOG2DB{1'b0}})) begin
            exp_keep_s = partial_keep(partial_r);
        end else begin
            exp_keep_s = {DB{1'b1}};
        end
        err_s[0] = chk_s && data_mismatch(axis_in_tdata, exp_pattern_s, exp_keep_s);
        err_s[1] = chk_s && (axis_in_tkeep != exp_keep_s);
        err_s[2] = chk_s && axis_in_tlast && (beat_r < nbeats_r);
        err_s[3] = chk_s && !axis_in_tlast && (beat_r == nbeats_r);
    end

    // Control FSM plus all registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r            <= ST_IDLE;
            nbeats_r           <= 16'd0;
            partial_r          <= {LOG2DB{1'b0}};
            count_r            <= 16'd0;
            stall_r            <= 8'd0;
            stall_ctr_r        <= 8'd0;
            exp_data_r         <= 16'd0;
            beat_r             <= 16'd0;
            pkt_r              <= 16'd0;
            tready_r           <= 1'b0;
            active_r           <= 1'b0;
            packets_rcvd_r     <= 16'd0;
            error_count_r      <= 16'd0;
            error_flags_r      <= 4'd0;
            first_err_packet_r <= 16'd0;
            first_err_cycle_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tready_r <= 1'b0;
                    if (arm_ok_s) begin
                        nbeats_r           <= arm_nbeats_s;
                        partial_r          <= arm_partial_s;
                        count_r            <= packet_count;
                        stall_r            <= stall_cycles;
                        exp_data_r         <= initial_value;
                        beat_r             <= 16'd1;
                        pkt_r              <= 16'd1;
                        packets_rcvd_r     <= 16'd0;
                        error_count_r      <= 16'd0;
                        error_flags_r      <= 4'd0;
                        first_err_packet_r <= 16'd0;
                        first_err_cycle_r  <= 16'd0;
                        tready_r           <= 1'b1;
                        active_r           <= 1'b1;
                        state_r            <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (hs_s) begin
                        if (err_s != 4'd0) begin
                            if (error_count_r != 16'hFFFF) begin
                                error_count_r <= error_count_r + 16'd1;
                            end
                            error_flags_r <= error_flags_r | err_s;
                            if (error_flags_r == 4'd0) begin
                                first_err_packet_r <= pkt_r;
                                first_err_cycle_r  <= beat_r;
                            end
                        end
                        exp_data_r <= exp_data_r + 16'd1;
                        if (beat_r != 16'hFFFF) begin
                            beat_r <= beat_r + 16'd1;
                        end
                        if (axis_in_tlast) begin
                            packets_rcvd_r <= packets_rcvd_r + 16'd1;
                            beat_r         <= 16'd1;
                        end
                        // Completion of the final packet takes priority over a stall.
                        if (axis_in_tlast && (pkt_r == count_r)) begin
                            tready_r <= 1'b0;
                            active_r <= 1'b0;
                            state_r  <= ST_IDLE;
                        end else begin
                            if (axis_in_tlast) begin
                                pkt_r <= pkt_r + 16'd1;
                            end
                            if (stall_r != 8'd0) begin
                                stall_ctr_r <= stall_r - 8'd1;
                                tready_r    <= 1'b0;
                                state_r     <= ST_STALL;
                            end
                        end
                    end
                end
                ST_STALL: begin
                    // tready is low for stall_r clocks; it rises as the counter hits zero.
                    if (stall_ctr_r == 8'd0) begin
                        tready_r <= 1'b1;
                        state_r  <= ST_RECV;
                    end else begin
                        stall_ctr_r <= stall_ctr_r - 8'd1;
                    end
                end
                default: begin
                    tready_r <= 1'b0;
                    active_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign active           = active_r;
    assign axis_in_tready   = tready_r;
    assign packets_rcvd     = packets_rcvd_r;
    assign error_count      = error_count_r;
    assign error_flags      = error_flags_r;
    assign first_err_packet = first_err_packet_r;
    assign first_err_cycle  = first_err_cycle_r;
endmodule

// File: tb/tb_packet_checker.sv
module tb_packet_checker;
    localparam int DW = 512;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     packet_length = 16'd0;
    logic [15:0]     packet_count = 16'd0;
    logic [15:0]     initial_value = 16'd0;
    logic [7:0]      stall_cycles = 8'd0;
    logic            start = 1'b0;
    logic            active;
    logic [DW-1:0]   tdata = '0;
    logic [DW/8-1:0] tkeep = '0;
    logic            tlast = 1'b0;
    logic            tvalid = 1'b0;
    logic            tready;
    logic [15:0]     packets_rcvd;
    logic [15:0]     error_count;
    logic [3:0]      error_flags;
    logic [15:0]     first_err_packet;
    logic [15:0]     first_err_cycle;

    packet_checker #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .packet_length(packet_length), .packet_count(packet_count),
        .initial_value(initial_value), .stall_cycles(stall_cycles),
        .start(start), .active(active),
        .axis_in_tdata(tdata), .axis_in_tkeep(tkeep), .axis_in_tlast(tlast),
        .axis_in_tvalid(tvalid), .axis_in_tready(tready),
        .packets_rcvd(packets_rcvd), .error_count(error_count),
        .error_flags(error_flags), .first_err_packet(first_err_packet),
        .first_err_cycle(first_err_cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pk;
        logic [15:0] ec;
        logic [3:0]  fl;
        logic [15:0] fp;
        logic [15:0] fc;
        logic        act;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic trace_on = 1'b0;
    logic trace[$];

    localparam logic [63:0] KALL = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic exp_t mk(input logic [15:0] pk, input logic [15:0] ec, input logic [3:0] fl,
                                input logic [15:0] fp, input logic [15:0] fc, input logic act);
        exp_t e;
        e.pk = pk; e.ec = ec; e.fl = fl; e.fp = fp; e.fc = fc; e.act = act;
        return e;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [15:0] v);
        return {(DW/16){v}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: on every accepted beat, pop the expected status and compare one clock later.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (tvalid && tready && !reset) begin
                @(posedge clk);
                #1;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("packets_rcvd", {16'd0, packets_rcvd}, {16'd0, e.pk});
                    chk("error_count", {16'd0, error_count}, {16'd0, e.ec});
                    chk("error_flags", {28'd0, error_flags}, {28'd0, e.fl});
                    chk("first_err_packet", {16'd0, first_err_packet}, {16'd0, e.fp});
                    chk("first_err_cycle", {16'd0, first_err_cycle}, {16'd0, e.fc});
                    chk("active", {31'd0, active}, {31'd0, e.act});
                end
            end
        end
    end

    // tready trace recorder used by the throttling test.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (trace_on && active) trace.push_back(tready);
        end
    end

    // Called at a negedge; returns at the negedge after the arm edge.
    task automatic arm(input logic [15:0] len, input logic [15:0] cnt,
                       input logic [15:0] init, input logic [7:0] stl);
        packet_length = len; packet_count = cnt; initial_value = init; stall_cycles = stl;
        tvalid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; presents a beat and returns at the negedge after its handshake.
    task automatic send_beat(input logic [DW-1:0] d, input logic [63:0] k, input logic l, input exp_t e);
        int waited;
        waited = 0;
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
        sb.push_back(e);
        while (!tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!tready) begin
            chk("handshake_timeout", 32'd1, 32'd0);
            void'(sb.pop_back());
            tvalid = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic idle_cycles(input int n);
        tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        #1;
        chk({tag, "_tready"}, {31'd0, tready}, 32'd0);
        chk({tag, "_active"}, {31'd0, active}, 32'd0);
        chk({tag, "_packets"}, {16'd0, packets_rcvd}, 32'd0);
        chk({tag, "_errcnt"}, {16'd0, error_count}, 32'd0);
        chk({tag, "_flags"}, {28'd0, error_flags}, 32'd0);
        chk({tag, "_fep"}, {16'd0, first_err_packet}, 32'd0);
        chk({tag, "_fec"}, {16'd0, first_err_cycle}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        int wait_n;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Zero length or zero count must not arm.
        arm(16'd0, 16'd1, 16'h0000, 8'd0);
        #1 chk("len0_ignored", {31'd0, active}, 32'd0);
        @(negedge clk);
        arm(16'd64, 16'd0, 16'h0000, 8'd0);
        #1 chk("cnt0_ignored", {31'd0, active}, 32'd0);
        @(negedge clk);

        // Test 1: clean stream, length 200 (N=4, partial 8), two packets.
        arm(16'd200, 16'd2, 16'h1234, 8'd0);
        send_beat(pat(16'h1234), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        send_beat(pat(16'h1235), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        // start while active with a different seed must be ignored
        packet_length = 16'd64; initial_value = 16'h0000;
        start = 1'b1; tvalid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        send_beat(pat(16'h1236), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        send_beat(pat(16'h1237), 64'hFF, 1'b1, mk(1, 0, 0, 0, 0, 1));
        send_beat(pat(16'h1238), KALL, 1'b0, mk(1, 0, 0, 0, 0, 1));
        send_beat(pat(16'h1239), KALL, 1'b0, mk(1, 0, 0, 0, 0, 1));
        send_beat(pat(16'h123A), KALL, 1'b0, mk(1, 0, 0, 0, 0, 1));
        send_beat(pat(16'h123B), 64'hFF, 1'b1, mk(2, 0, 0, 0, 0, 0));
        idle_cycles(2);

        // Test 2: corrupted byte 5 on beat 2; corruption outside tkeep on beat 4 ignored.
        arm(16'd200, 16'd2, 16'h1234, 8'd0);
        send_beat(pat(16'h1234), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        d = pat(16'h1235); d[47:40] = ~d[47:40];
        send_beat(d, KALL, 1'b0, mk(0, 1, 1, 1, 2, 1));
        send_beat(pat(16'h1236), KALL, 1'b0, mk(0, 1, 1, 1, 2, 1));
        d = pat(16'h1237); d[71:64] = ~d[71:64]; d[487:480] = ~d[487:480];
        send_beat(d, 64'hFF, 1'b1, mk(1, 1, 1, 1, 2, 1));
        send_beat(pat(16'h1238), KALL, 1'b0, mk(1, 1, 1, 1, 2, 1));
        send_beat(pat(16'h1239), KALL, 1'b0, mk(1, 1, 1, 1, 2, 1));
        send_beat(pat(16'h123A), KALL, 1'b0, mk(1, 1, 1, 1, 2, 1));
        send_beat(pat(16'h123B), 64'hFF, 1'b1, mk(2, 1, 1, 1, 2, 0));
        idle_cycles(2);

        // Test 3: length 256, tlast early on beat 3, then a clean packet.
        arm(16'd256, 16'd2, 16'h0100, 8'd0);
        send_beat(pat(16'h0100), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        send_beat(pat(16'h0101), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        send_beat(pat(16'h0102), KALL, 1'b1, mk(1, 1, 4, 1, 3, 1));
        send_beat(pat(16'h0103), KALL, 1'b0, mk(1, 1, 4, 1, 3, 1));
        send_beat(pat(16'h0104), KALL, 1'b0, mk(1, 1, 4, 1, 3, 1));
        send_beat(pat(16'h0105), KALL, 1'b0, mk(1, 1, 4, 1, 3, 1));
        send_beat(pat(16'h0106), KALL, 1'b1, mk(2, 1, 4, 1, 3, 0));
        idle_cycles(2);

        // Test 4: length 64 (N=1), tlast withheld until beat 3; beats 2-3 unchecked.
        arm(16'd64, 16'd1, 16'hFFFE, 8'd0);
        send_beat(pat(16'hFFFE), KALL, 1'b0, mk(0, 1, 8, 1, 1, 1));
        send_beat(pat(16'hA5A5), 64'h0, 1'b0, mk(0, 1, 8, 1, 1, 1));
        send_beat(pat(16'h5A5A), 64'h3, 1'b1, mk(1, 1, 8, 1, 1, 0));
        idle_cycles(2);

        // Test 5: stall 3, tvalid always high, 8 beats crossing the counter wrap.
        trace.delete();
        trace_on = 1'b1;
        arm(16'd512, 16'd1, 16'hFFFC, 8'd3);
        for (int i = 0; i < 7; i++) begin
            send_beat(pat(16'hFFFC + 16'(i)), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        end
        send_beat(pat(16'h0003), KALL, 1'b1, mk(1, 0, 0, 0, 0, 0));
        idle_cycles(2);
        trace_on = 1'b0;
        chk("stall_trace_len", trace.size(), 32'd29);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < trace.size(); i++) begin
                if (trace[i] !== ((i % 4) == 0)) bad++;
            end
            chk("stall_tready_pattern", bad, 32'd0);
        end

        // Test 6: reset on beat 2 of packet 1 (after an error), then a fresh clean run.
        arm(16'd128, 16'd1, 16'h5555, 8'd0);
        d = pat(16'h5555); d[7:0] = ~d[7:0];
        send_beat(d, KALL, 1'b0, mk(0, 1, 1, 1, 1, 1));
        tdata = pat(16'h5556); tkeep = KALL; tlast = 1'b1; tvalid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tvalid = 1'b0;
        check_all_zero("midreset");
        @(negedge clk);
        arm(16'd128, 16'd1, 16'h0001, 8'd0);
        send_beat(pat(16'h0001), KALL, 1'b0, mk(0, 0, 0, 0, 0, 1));
        send_beat(pat(16'h0002), KALL, 1'b1, mk(1, 0, 0, 0, 0, 0));
        idle_cycles(2);

        wait_n = 0;
        while (sb.size() != 0 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
